// File: rtl/ptcalc_mul_pkg.sv
// Shared types, widths and round-robin helpers for the pt-calc multiplier arbiter.
package ptcalc_mul_pkg;

  localparam int unsigned MUL_A_W  = 19;
  localparam int unsigned MUL_B_W  = 12;
  localparam int unsigned MUL_P_W  = 31;
  localparam int unsigned RR_MAX   = 8;
  localparam int unsigned RR_IDX_W = 3;
  localparam int unsigned RR_J_W   = 4;

  typedef logic signed [MUL_A_W-1:0] mul_a_t;
  typedef logic signed [MUL_B_W-1:0] mul_b_t;
  typedef logic signed [MUL_P_W-1:0] mul_p_t;

  typedef struct packed {
    logic                hit;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int unsigned n);
    rr_pick_t          r;
    logic [RR_J_W-1:0] j;
    r = '0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      j = RR_J_W'(ptr) + RR_J_W'(i);
      if (j >= RR_J_W'(n)) j = j - RR_J_W'(n);
      if (!r.hit && (i < n) && valid[j[RR_IDX_W-1:0]]) begin
        r.hit = 1'b1;
        r.idx = j[RR_IDX_W-1:0];
      end
    end
    return r;
  endfunction

  // Index after idx, wrapping at n (handles non-power-of-2 n).
  function automatic logic [RR_IDX_W-1:0] rr_inc(input logic [RR_IDX_W-1:0] idx,
                                                 input int unsigned n);
    logic [RR_J_W-1:0] s;
    s = RR_J_W'(idx) + RR_J_W'(1);
    return (s >= RR_J_W'(n)) ? '0 : s[RR_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/ptcalc_mul_pipe.sv
// Signed 19x12 multiplier followed by MUL_LAT data/id/valid register stages.
module ptcalc_mul_pipe
  import ptcalc_mul_pkg::*;
#(
  parameter int unsigned ID_W    = 2,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               op_valid,
  input  logic [MUL_A_W-1:0] op_a,
  input  logic [MUL_B_W-1:0] op_b,
  input  logic [ID_W-1:0]    op_id,
  output logic               res_valid,
  output logic [MUL_P_W-1:0] res_p,
  output logic [ID_W-1:0]    res_id,
  output logic               busy
);

  mul_p_t prod;

  // Both operands sign-extended to the product width; 19+12 bits never overflow 31.
  assign prod = MUL_P_W'($signed(op_a)) * MUL_P_W'($signed(op_b));

  if (MUL_LAT == 0) begin : g_nolat
    // Operand register loads only on grant, so the product already holds between results.
    assign res_valid = op_valid;
    assign res_p     = prod;
    assign res_id    = op_id;
    assign busy      = 1'b0;
  end else begin : g_lat
    logic [MUL_LAT-1:0] vld;
    mul_p_t             p_q  [MUL_LAT];
    logic [ID_W-1:0]    id_q [MUL_LAT];

    // Data stages load only behind a valid entry so the output holds otherwise.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
        vld <= '0;
        for (int unsigned s = 0; s < MUL_LAT; s++) begin
          p_q[s]  <= '0;
          id_q[s] <= '0;
        end
      end else begin
        vld[0] <= op_valid;
        if (op_valid) begin
          p_q[0]  <= prod;
          id_q[0] <= op_id;
        end
        for (int unsigned s = 1; s < MUL_LAT; s++) begin
          vld[s] <= vld[s-1];
          if (vld[s-1]) begin
            p_q[s]  <= p_q[s-1];
            id_q[s] <= id_q[s-1];
          end
        end
      end
    end

    assign res_valid = vld[MUL_LAT-1];
    assign res_p     = p_q[MUL_LAT-1];
    assign res_id    = id_q[MUL_LAT-1];
    assign busy      = |vld;
  end

endmodule

// File: rtl/ptcalc_mul_arbiter.sv
// Round-robin arbiter sharing one signed multiplier between NUM_REQ pt-calc requesters.
module ptcalc_mul_arbiter
  import ptcalc_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic                       arb_en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*MUL_A_W-1:0] req_a,
  input  logic [NUM_REQ*MUL_B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       res_valid,
  output logic [MUL_P_W-1:0]         res_p,
  output logic [ID_W-1:0]            res_id,
  output logic                       busy
);

  logic [ID_W-1:0]    rr_ptr;
  rr_pick_t           pick;
  logic               grant;
  logic [MUL_A_W-1:0] sel_a;
  logic [MUL_B_W-1:0] sel_b;
  logic               op_valid;
  logic [MUL_A_W-1:0] op_a;
  logic [MUL_B_W-1:0] op_b;
  logic [ID_W-1:0]    op_id;
  logic               pipe_busy;

  // Same-cycle grant and operand mux for the winning requester.
  always_comb begin
    pick      = rr_pick(RR_MAX'(req_valid), RR_IDX_W'(rr_ptr), NUM_REQ);
    grant     = arb_en & pick.hit;
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (RR_IDX_W'(i) == pick.idx) begin
        sel_a        = req_a[MUL_A_W*i +: MUL_A_W];
        sel_b        = req_b[MUL_B_W*i +: MUL_B_W];
        req_ready[i] = grant & ~ap_rst;
      end
    end
  end

  // Pointer and operand register; operand data only reloads on a grant.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rr_ptr   <= '0;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_id    <= '0;
    end else begin
      op_valid <= grant;
      if (grant) begin
        rr_ptr <= ID_W'(rr_inc(pick.idx, NUM_REQ));
        op_a   <= sel_a;
        op_b   <= sel_b;
        op_id  <= ID_W'(pick.idx);
      end
    end
  end

  ptcalc_mul_pipe #(
    .ID_W    (ID_W),
    .MUL_LAT (MUL_LAT)
  ) u_pipe (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .op_valid  (op_valid),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_id     (op_id),
    .res_valid (res_valid),
    .res_p     (res_p),
    .res_id    (res_id),
    .busy      (pipe_busy)
  );

  assign busy = op_valid | pipe_busy;

endmodule

// File: tb/tb_ptcalc_mul_arbiter.sv
// Directed bench for ptcalc_mul_arbiter: 4-requester instance plus a 3-requester wrap check.
module tb_ptcalc_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        arb_en;
  logic [3:0]  req_valid;
  logic [75:0] req_a;
  logic [47:0] req_b;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [30:0] res_p;
  logic [1:0]  res_id;
  logic        busy;

  logic [2:0]  req_valid3;
  logic [56:0] req_a3;
  logic [35:0] req_b3;
  logic [2:0]  req_ready3;
  logic        res_valid3;
  logic [30:0] res_p3;
  logic [1:0]  res_id3;
  logic        busy3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ptcalc_mul_arbiter #(.NUM_REQ(4), .ID_W(2), .MUL_LAT(2)) dut (
    .ap_clk(clk), .ap_rst(rst), .arb_en(arb_en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .res_valid(res_valid), .res_p(res_p), .res_id(res_id), .busy(busy)
  );

  ptcalc_mul_arbiter #(.NUM_REQ(3), .ID_W(2), .MUL_LAT(2)) dut3 (
    .ap_clk(clk), .ap_rst(rst), .arb_en(arb_en),
    .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3), .req_ready(req_ready3),
    .res_valid(res_valid3), .res_p(res_p3), .res_id(res_id3), .busy(busy3)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[19*i +: 19] = 19'(a);
    req_b[12*i +: 12] = 12'(b);
  endtask

  task automatic set_req3(input int i, input int a, input int b);
    req_a3[19*i +: 19] = 19'(a);
    req_b3[12*i +: 12] = 12'(b);
  endtask

  task automatic check_res(input string tag, input int p, input int id);
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_p"}, $signed(res_p), p);
    check({tag, "_id"}, res_id, id);
  endtask

  initial begin
    rst = 1'b1; arb_en = 1'b1;
    req_valid = 4'b0010; req_a = '0; req_b = '0;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0;

    // Reset state; requester 1 is already valid but must not see ready.
    mid();
    check("rst_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_p", $signed(res_p), 0);
    check("rst_res_id", res_id, 0);
    check("rst_busy", busy, 0);

    // Single requester, most-negative operands, latency t+3.
    set_req(1, -262144, -2048);
    tick(); rst = 1'b0;
    mid(); check("single_grant", req_ready, 4'b0010);
    tick(); req_valid = '0;
    mid(); check("single_t1_valid", res_valid, 0); check("single_t1_busy", busy, 1);
    tick(); mid(); check("single_t2_valid", res_valid, 0);
    tick(); mid(); check_res("single_t3", 536870912, 1);
    tick(); mid();
    check("single_t4_valid", res_valid, 0);
    check("single_hold_p", $signed(res_p), 536870912);
    check("single_t4_busy", busy, 0);

    // Sign extension of a small negative product; rr_ptr becomes 3.
    tick(); req_valid = 4'b0100; set_req(2, 3, -5);
    mid(); check("sext_grant", req_ready, 4'b0100);
    tick(); req_valid = '0;
    tick(); tick(); mid(); check_res("sext", -15, 2);

    // rr_ptr = 3 with requesters 0 and 2: wrap to 0, then 2, then ptr sits at 3.
    tick(); set_req(0, 7, 2); set_req(2, -4, 6); set_req(3, 5, 5); req_valid = 4'b0101;
    mid(); check("wrap_grant0", req_ready, 4'b0001);
    tick(); req_valid = 4'b0100;
    mid(); check("wrap_grant2", req_ready, 4'b0100);
    tick(); req_valid = 4'b1111;
    mid(); check("wrap_ptr3", req_ready, 4'b1000);
    tick(); req_valid = '0;
    mid(); check_res("wrap_r0", 14, 0);
    tick(); mid(); check_res("wrap_r2", -24, 2);
    tick(); mid(); check_res("wrap_r3", 25, 3);
    tick(); mid(); check("wrap_idle_valid", res_valid, 0); check("wrap_idle_busy", busy, 0);

    // All four valid continuously: grants 0,1,2,3,0 and back-to-back results.
    for (int i = 0; i < 4; i++) set_req(i, i + 1, 10);
    for (int k = 0; k < 9; k++) begin
      tick(); req_valid = (k < 5) ? 4'b1111 : 4'b0000;
      mid();
      if (k < 5) check($sformatf("rot_grant%0d", k), req_ready, 4'b0001 << (k % 4));
      if (k >= 3 && k < 8) check_res($sformatf("rot_res%0d", k - 3), ((k - 3) % 4 + 1) * 10, (k - 3) % 4);
      if (k == 8) check("rot_idle_busy", busy, 0);
    end

    // arb_en falls with two products in flight (rr_ptr = 1).
    tick(); req_valid = 4'b1111;
    mid(); check("en_grant1", req_ready, 4'b0010);
    tick(); mid(); check("en_grant2", req_ready, 4'b0100);
    tick(); arb_en = 1'b0;
    mid(); check("en_off_ready", req_ready, 0);
    tick(); mid(); check_res("en_r1", 20, 1); check("en_off_ready2", req_ready, 0);
    tick(); mid(); check_res("en_r2", 30, 2); check("en_busy_last", busy, 1);
    tick(); mid(); check("en_drain_valid", res_valid, 0); check("en_drain_busy", busy, 0);
    tick(); req_valid = '0; arb_en = 1'b1;

    // Asynchronous reset mid-clock with three products in flight (rr_ptr = 3).
    tick(); req_valid = 4'b1111;
    mid(); check("ar_grant3", req_ready, 4'b1000);
    tick(); mid(); check("ar_grant0", req_ready, 4'b0001);
    tick(); mid(); check("ar_grant1", req_ready, 4'b0010);
    tick(); #2;
    check("ar_pre_busy", busy, 1);
    check_res("ar_pre", 40, 3);
    rst = 1'b1;
    #1;
    check("ar_valid_drop", res_valid, 0);
    check("ar_busy_drop", busy, 0);
    check("ar_ready_drop", req_ready, 0);
    tick();
    tick(); rst = 1'b0; req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      mid(); check($sformatf("ar_nostale%0d", k), res_valid, 0);
      check($sformatf("ar_idle_busy%0d", k), busy, 0);
      tick();
    end
    req_valid = 4'b1111;
    mid(); check("ar_first_grant", req_ready, 4'b0001);
    tick(); req_valid = '0;
    tick(); tick(); mid(); check_res("ar_first_res", 10, 0);

    // NUM_REQ = 3: grant to index 2 wraps rr_ptr to 0.
    tick(); req_valid3 = 3'b100; set_req3(2, 2, -3); set_req3(0, 4, 4); set_req3(1, 9, 9);
    mid(); check("n3_grant2", req_ready3, 3'b100);
    tick(); req_valid3 = 3'b011;
    mid(); check("n3_grant0", req_ready3, 3'b001);
    tick(); req_valid3 = '0;
    tick(); mid();
    check("n3_r2_valid", res_valid3, 1);
    check("n3_r2_p", $signed(res_p3), -6);
    check("n3_r2_id", res_id3, 2);
    tick(); mid();
    check("n3_r0_valid", res_valid3, 1);
    check("n3_r0_p", $signed(res_p3), 16);
    check("n3_r0_id", res_id3, 0);
    tick(); mid(); check("n3_idle_busy", busy3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ptcalc_mul_arbiter.md
Name: ptcalc_mul_arbiter

Overview:
- Shares one signed 19x12 -> 31-bit multiplier between NUM_REQ requesters inside the pt-calculation datapath.
- Uses a round-robin grant with one operand pair accepted per cycle.
- Pipelines the product and returns it tagged with the requester index.
- Sits between the pt-calc stages that issue products (slope/radius terms) and the shared DSP resource, so only one DSP is instantiated for all of them.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, requester index width; must equal ceil(log2(NUM_REQ)).
- MUL_LAT, 2, register stages after the multiply; legal range 0..4.

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  asynchronous active-high reset.
- arb_en  in  1  when low, no new grants; in-flight products drain normally.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_a  in  NUM_REQ*19  packed signed operand A; requester i occupies bits [19*i+18:19*i].
- req_b  in  NUM_REQ*12  packed signed operand B; requester i occupies bits [12*i+11:12*i].
- req_ready  out  NUM_REQ  one-hot grant; operands transfer when req_valid[i] and req_ready[i] are both high.
- res_valid  out  1  product valid, one-cycle pulse per accepted request.
- res_p  out  31  signed product.
- res_id  out  ID_W  index of the requester that issued the product.
- busy  out  1  high when any pipeline stage holds a valid entry.

Behaviour:
- Reset is asynchronous, active-high, applied to every register. Reset values:
  - rr_ptr = 0.
  - All pipeline valid bits = 0.
  - res_valid = 0, res_p = 0, res_id = 0, busy = 0.
- While ap_rst is high, req_ready is forced to 0.
- Grant (combinational, same cycle):
  - Search req_valid starting at index rr_ptr, ascending, wrapping from NUM_REQ-1 to 0.
  - The first set bit g receives req_ready[g] = 1. At most one req_ready bit is high.
  - If arb_en = 0 or req_valid = 0, req_ready = 0.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- rr_ptr update:
  - On a grant to g, rr_ptr <= (g+1) mod NUM_REQ. Wrap applies for non-power-of-2 NUM_REQ; g = NUM_REQ-1 gives 0.
  - No grant: rr_ptr holds.
- Requester obligations: once req_valid is high, the requester holds req_valid, req_a and req_b stable until granted.
- Issue stage, on the cycle of a grant:
  - Capture a = req_a slice g, b = req_b slice g, id = g, and valid = 1 into the operand register.
  - With no grant, valid = 0; the data registers may hold stale values.
- Multiply:
  - The sub-module computes a full-precision signed product of the registered operands, sign-extended to 31 bits, with no truncation or saturation.
  - The result then passes through MUL_LAT register stages.
  - The id and valid tags travel in a shift register of matching depth.
- Latency:
  - A request accepted in cycle t produces res_valid = 1 in cycle t+1+MUL_LAT.
  - With MUL_LAT = 0, the result is registered once (t+1).
  - Throughput is one product per cycle; results return in grant order.
- Outputs:
  - res_p and res_id update only when the last-stage valid is 1; otherwise they hold their previous values.
  - res_valid is the last-stage valid bit.
- Back-pressure: there is none on the result side. Consumers must accept res_valid on the cycle it is high.
- busy is the OR of all stage valid bits, operand register included.
- Simultaneous events:
  - All requesters valid: grants rotate 0,1,2,3,0,... with one grant per cycle.
  - If a requester drops and re-asserts, rotation continues from rr_ptr.
- arb_en falling mid-stream: no further grants. Entries already issued complete, and busy falls after the last one exits.
- Reset mid-operation: all in-flight products are discarded with no res_valid emitted, and rr_ptr returns to 0.

Decomposition:
- ptcalc_mul_pkg holds:
  - Constants MUL_A_W = 19, MUL_B_W = 12, MUL_P_W = 31.
  - Typedefs for the operand and product signed types.
  - A function for round-robin next-index selection.
- One sub-module, ptcalc_mul_pipe, holds the signed multiplier plus the MUL_LAT data, id and valid pipeline.
- The arbiter top holds the grant logic, rr_ptr, and the operand register.

Test Plan:
- Single requester, MUL_LAT = 2:
  - Stimulus: req 1 valid with a = -262144, b = -2048, accepted in cycle t.
  - Response: res_valid in cycle t+3 with res_p = 536870912 and res_id = 1.
  - Sign-extension case: a = 3, b = -5 gives res_p = -15.
- All four requesters valid continuously with a = i+1, b = 10:
  - Grants follow 0,1,2,3,0 on consecutive cycles.
  - Results follow res_p 10,20,30,40,10 with res_id 0,1,2,3,0, back-to-back.
- rr_ptr = 3 with requesters 0 and 2 valid:
  - Grant goes to 0 (wrap), then 2, and rr_ptr ends at 3.
  - Repeat with NUM_REQ = 3 and a grant to index 2: rr_ptr = 0.
- arb_en deasserted while 2 products are in flight:
  - No new req_ready; both results emerge.
  - busy goes low the cycle after the last res_valid.
- ap_rst asserted asynchronously mid-clock with 3 products in flight:
  - res_valid, busy and req_ready go to 0 immediately.
  - No stale result appears after reset is released.
  - The first grant after release goes to index 0.
